hazard_ctrl: RTL

- Parametrised next-generation hazard/interlock controller for the 5-stage MIPS-style pipeline, sitting beside the ID stage and driving PC, IF/ID and ID/EX enables.
- Load-use interlock generalised to a configurable load latency via a small load-destination scoreboard.
- Adds taken-branch flush, memory-wait freeze, a latched HALTED state and a saturating load-stall counter.

---
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/interlock controller for a 5-stage pipeline: load-use scoreboard, branch flush,
// memory-wait freeze, sticky HALTED state. Stall counter only with HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
   parameter int               REG_W    = 5,
   parameter int               OP_W     = 6,
   parameter logic [OP_W-1:0]  HALT_OP  = 6'h3f,
   parameter int               LOAD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      d_instr,
   input  logic             d_valid,
   input  logic [REG_W-1:0] x_rt,
   input  logic             x_memread,
   input  logic             x_valid,
   input  logic             x_branch_taken,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic             halted,
   output logic [15:0]      stall_cnt
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [REG_W-1:0] rs_s;
   logic [REG_W-1:0] rt_s;
   logic             ex_load_s;
   logic             ex_hit_s;
   logic             sb_hit_s;
   logic             load_haz_s;
   logic             halt_dec_s;
   logic             unused_s;

   assign rs_s       = d_instr[21 +: REG_W];
   assign rt_s       = d_instr[16 +: REG_W];
   assign unused_s   = ^d_instr[15:0];
   // x_rt != 0 keeps register 0 from ever matching
   assign ex_load_s  = x_valid & x_memread & (x_rt != {REG_W{1'b0}});
   assign ex_hit_s   = ex_load_s & ((x_rt == rs_s) | (x_rt == rt_s));
   assign load_haz_s = d_valid & (ex_hit_s | sb_hit_s);
   assign halt_dec_s = d_valid & (d_instr[31 -: OP_W] == HALT_OP);

   generate
      if (LOAD_LAT > 1) begin : g_sb
         localparam int SB_N = LOAD_LAT - 1;
         logic [SB_N-1:0]  sb_valid_r;
         logic [REG_W-1:0] sb_tag_r [SB_N];

         // Age loads that left EX; frozen while memory is not ready
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sb_valid_r <= {SB_N{1'b0}};
               for (int k = 0; k < SB_N; k++) begin
                  sb_tag_r[k] <= {REG_W{1'b0}};
               end
            end else if (mem_ready) begin
               sb_valid_r[0] <= ex_load_s;
               sb_tag_r[0]   <= x_rt;
               for (int k = 1; k < SB_N; k++) begin
                  sb_valid_r[k] <= sb_valid_r[k-1];
                  sb_tag_r[k]   <= sb_tag_r[k-1];
               end
            end else begin
               sb_valid_r <= sb_valid_r;
            end
         end

         // Match ID source registers against every live scoreboard tag
         always_comb begin
            sb_hit_s = 1'b0;
            for (int k = 0; k < SB_N; k++) begin
               if (sb_valid_r[k] && ((sb_tag_r[k] == rs_s) || (sb_tag_r[k] == rt_s))) begin
                  sb_hit_s = 1'b1;
               end else begin
                  sb_hit_s = sb_hit_s;
               end
            end
         end
      end else begin : g_no_sb
         assign sb_hit_s = 1'b0;
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state: a halt commits only once it is clear of hazards, flushes and freezes
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         RUN: begin
            if (halt_dec_s && !load_haz_s && !x_branch_taken && mem_ready) begin
               state_nxt_s = HALTED;
            end else begin
               state_nxt_s = RUN;
            end
         end
         HALTED:  state_nxt_s = HALTED;
         default: state_nxt_s = RUN;
      endcase
   end

   // Pipeline enables by priority: reset, freeze, flush, halted, interlock, run
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      if (!rst_n) begin
         {pc_en, ifid_en, idex_bubble, ifid_flush} = 4'b0010;
      end else if (!mem_ready) begin
         {pc_en, ifid_en, idex_bubble, ifid_flush} = 4'b0000;
      end else if (x_branch_taken) begin
         {pc_en, ifid_en, idex_bubble, ifid_flush} = 4'b1111;
      end else if (state_r == HALTED) begin
         {pc_en, ifid_en, idex_bubble, ifid_flush} = 4'b0010;
      end else if (load_haz_s || halt_dec_s) begin
         {pc_en, ifid_en, idex_bubble, ifid_flush} = 4'b0010;
      end else begin
         {pc_en, ifid_en, idex_bubble, ifid_flush} = 4'b1100;
      end
   end

   assign halted = (state_r == HALTED);

`ifdef HAZARD_STALL_CNT_EN
   logic [15:0] stall_cnt_r;
   logic        stall_inc_s;

   assign stall_inc_s = load_haz_s & mem_ready & ~x_branch_taken & (state_r == RUN);

   // Saturating count of load-use stall cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= 16'h0000;
      end else if (stall_inc_s && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule
